// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
// Holds the access-size and FSM state encodings plus the lane-mask,
// store-replication and load-extension functions used by dmem_bytelane.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int WORD_W = 32;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input size_t size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [WORD_W-1:0] store_replicate(input size_t size,
                                                       input logic [WORD_W-1:0] wdata);
    logic [WORD_W-1:0] r;
    case (size)
      SZ_B:    r = {4{wdata[7:0]}};
      SZ_H:    r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                   input size_t size,
                                                   input logic [1:0] off,
                                                   input logic uns);
    logic [WORD_W-1:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [WORD_W-1:0] r;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      SZ_B:    r = uns ? {24'd0, sh[7:0]}  : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, sh[15:0]} : {{16{h[15]}}, h};
      SZ_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Storage array for dmem_bytelane: four independent 8-bit lanes sharing one
// word index, per-lane write enables, synchronous write and a registered
// full-word read. Contents are never reset.
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     wmask,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] q;

    // Lane write on a masked access; every access also samples the lane.
    always_ff @(posedge clk) begin
      if (en && wmask[g]) begin
        mem[idx] <= wdata[8*g +: 8];
      end
      if (en) begin
        q <= mem[idx];
      end
    end

    assign rdata[8*g +: 8] = q;
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with request/response handshake for the load/store
// path. Byte/half/word stores with lane masks, size-aware sign/zero-extended
// loads, range and size error flags, and a fixed response latency.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; without it the low address bits are forced to alignment.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  size_t       size_in;
  logic        accept;
  logic        range_err;
  logic        size_err;
  logic        mis_err;
  logic        acc_err;
  logic [1:0]  off_raw;
  logic [1:0]  off;
  logic [3:0]  wmask;
  logic [31:0] wdata_rep;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_word;

  size_t       size_p0;
  logic [1:0]  off_p0;
  logic        uns_p0;
  logic        we_p0;
  logic        err_p0;
  logic        vld_p0;
  logic [31:0] data_p0;
  logic        rerr_p0;

  // Request decode: errors, aligned lane offset, write mask and lane data.
  assign size_in   = size_t'(req_size);
  assign accept    = req_valid & req_ready;
  assign range_err = |(req_addr >> (IDX_W + 2));
  assign size_err  = (size_in == SZ_ILL);
  assign off_raw   = req_addr[1:0];
  assign idx       = req_addr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_err = ((size_in == SZ_H) && off_raw[0]) ||
                   ((size_in == SZ_W) && (off_raw != 2'b00));
  assign off     = off_raw;
`else
  assign mis_err = 1'b0;
  assign off     = (size_in == SZ_H) ? {off_raw[1], 1'b0} :
                   (size_in == SZ_W) ? 2'b00 : off_raw;
`endif

  assign acc_err   = range_err | size_err | mis_err;
  assign wmask     = (req_we && !acc_err) ? lane_mask(size_in, off) : 4'b0000;
  assign wdata_rep = store_replicate(size_in, req_wdata);

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (accept),
    .wmask(wmask),
    .idx  (idx),
    .wdata(wdata_rep),
    .rdata(rd_word)
  );

  // ---- stage p0: access attributes captured alongside the RAM read ----
  // Capture lane-extraction attributes on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_p0 <= size_in;
      off_p0  <= off;
      uns_p0  <= req_unsigned;
      we_p0   <= req_we;
      err_p0  <= acc_err;
    end
  end

  // Marks that p0 holds a real access, so outputs read as zero after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
    end
  end

  assign data_p0 = (vld_p0 && !we_p0 && !err_p0) ?
                   load_extend(rd_word, size_p0, off_p0, uns_p0) : 32'd0;
  assign rerr_p0 = vld_p0 & err_p0;

  // Control FSM: accept, wait out the latency, raise the response pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              req_ready <= 1'b1;
            end else begin
              state     <= WAIT;
              cnt       <= CNT_INIT;
              rsp_valid <= 1'b0;
              req_ready <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---- stage p1: response data register ----
  if (LATENCY == 1) begin : g_direct
    // Every accept edge is also a response edge, so p0 already behaves as
    // the response register.
    assign rsp_rdata = data_p0;
    assign rsp_err   = rerr_p0;
  end else begin : g_held
    logic        rsp_load;
    logic [31:0] rdata_p1;
    logic        err_p1;

    assign rsp_load = (state == WAIT) && (cnt == '0);

    // Load the response only on the edge that raises rsp_valid.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rdata_p1 <= 32'd0;
        err_p1   <= 1'b0;
      end else if (rsp_load) begin
        rdata_p1 <= data_p0;
        err_p1   <= rerr_p0;
      end
    end

    assign rsp_rdata = rdata_p1;
    assign rsp_err   = err_p1;
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: one instance at LATENCY=1, one at
// LATENCY=3, driven from a byte-level reference model.
module tb_dmem_bytelane;

  localparam int DEPTH = 1024;
  localparam int NBYTE = DEPTH * 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic        req_valid_s   [2];
  logic        req_ready_s   [2];
  logic        req_we_s      [2];
  logic [1:0]  req_size_s    [2];
  logic        req_unsigned_s[2];
  logic [31:0] req_addr_s    [2];
  logic [31:0] req_wdata_s   [2];
  logic        rsp_valid_s   [2];
  logic [31:0] rsp_rdata_s   [2];
  logic        rsp_err_s     [2];

  logic [7:0] mem_m [2][NBYTE];
  exp_t sb0[$];
  exp_t sb1[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bytelane #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_we(req_we_s[0]),
    .req_size(req_size_s[0]), .req_unsigned(req_unsigned_s[0]), .req_addr(req_addr_s[0]),
    .req_wdata(req_wdata_s[0]), .rsp_valid(rsp_valid_s[0]), .rsp_rdata(rsp_rdata_s[0]),
    .rsp_err(rsp_err_s[0]));

  dmem_bytelane #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_we(req_we_s[1]),
    .req_size(req_size_s[1]), .req_unsigned(req_unsigned_s[1]), .req_addr(req_addr_s[1]),
    .req_wdata(req_wdata_s[1]), .rsp_valid(rsp_valid_s[1]), .rsp_rdata(rsp_rdata_s[1]),
    .rsp_err(rsp_err_s[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Reference behaviour of one access, applied to the byte model.
  task automatic model(input int i, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    logic [31:0] a;
    int n;
    a   = addr;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (addr >= NBYTE);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz != 2'd0 && sz != 2'd3 && (a % n) != 0) err = 1'b1;
`else
    if (sz != 2'd3) a = a - (a % n);
`endif
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < n; b++) mem_m[i][a + b] = wd[8*b +: 8];
      end else begin
        for (int b = 0; b < n; b++) rd[8*b +: 8] = mem_m[i][a + b];
        if (!uns && n < 4 && rd[8*n-1]) begin
          for (int k = 8*n; k < 32; k++) rd[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic issue(input int i, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit now);
    int w;
    exp_t e;
    logic [31:0] er;
    logic ee;
    w = 0;
    if (!now) @(negedge clk);
    while (!req_ready_s[i] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 32'd0, 32'd1);
    req_we_s[i]       = we;
    req_size_s[i]     = sz;
    req_unsigned_s[i] = uns;
    req_addr_s[i]     = addr;
    req_wdata_s[i]    = wd;
    req_valid_s[i]    = 1'b1;
    @(posedge clk);
    #1;
    req_valid_s[i] = 1'b0;
    model(i, we, sz, uns, addr, wd, er, ee);
    e.rdata = er;
    e.err   = ee;
    e.due   = cyc + lat(i) - 1;
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic st(input int i, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    issue(i, 1'b1, sz, 1'b0, addr, wd, 1'b0);
  endtask

  task automatic ld(input int i, input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    issue(i, 1'b0, sz, uns, addr, 32'd0, 1'b0);
  endtask

  task automatic suite(input int i);
    st(i, 2'd2, 32'h10, 32'hDEADBEEF);
    ld(i, 2'd2, 1'b0, 32'h10);
    st(i, 2'd0, 32'h13, 32'h00000080);
    ld(i, 2'd0, 1'b0, 32'h13);
    ld(i, 2'd0, 1'b1, 32'h13);
    ld(i, 2'd2, 1'b0, 32'h10);
    st(i, 2'd2, 32'h20, 32'hCAFEF00D);
    st(i, 2'd1, 32'h22, 32'h00001234);
    ld(i, 2'd1, 1'b0, 32'h22);
    ld(i, 2'd2, 1'b0, 32'h20);
    st(i, 2'd1, 32'h20, 32'h00008001);
    ld(i, 2'd1, 1'b0, 32'h20);
    ld(i, 2'd1, 1'b1, 32'h20);
    st(i, 2'd2, NBYTE, 32'h55555555);
    ld(i, 2'd2, 1'b0, NBYTE);
    ld(i, 2'd2, 1'b0, 32'h10);
    st(i, 2'd3, 32'h10, 32'h77777777);
    ld(i, 2'd3, 1'b0, 32'h10);
    ld(i, 2'd2, 1'b0, 32'h10);
    st(i, 2'd0, NBYTE - 1, 32'h0000005A);
    ld(i, 2'd0, 1'b1, NBYTE - 1);
    ld(i, 2'd0, 1'b0, 32'h80000010);
    st(i, 2'd2, 32'h30, 32'h00000000);
    st(i, 2'd2, 32'h31, 32'h11223344);
    ld(i, 2'd2, 1'b0, 32'h30);
    for (int a = 32'h40; a < 32'h80; a += 4) st(i, 2'd2, a, $urandom);
    for (int k = 0; k < 24; k++) begin
      issue(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(32'h40, 32'h7F)), $urandom, 1'b0);
    end
  endtask

  // Response checkers: pop the expected response when the DUT answers.
  always @(negedge clk) begin
    if (rstn && rsp_valid_s[0]) begin
      exp_t e;
      if (sb0.size() == 0) chk("stray_rsp0", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        chk("rdata0", rsp_rdata_s[0], e.rdata);
        chk("err0", 32'(rsp_err_s[0]), 32'(e.err));
        chk("lat0", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && rsp_valid_s[1]) begin
      exp_t e;
      if (sb1.size() == 0) chk("stray_rsp1", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        chk("rdata1", rsp_rdata_s[1], e.rdata);
        chk("err1", 32'(rsp_err_s[1]), 32'(e.err));
        chk("lat1", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < 2; i++) begin
      req_valid_s[i] = 1'b0; req_we_s[i] = 1'b0; req_size_s[i] = 2'd0;
      req_unsigned_s[i] = 1'b0; req_addr_s[i] = 32'd0; req_wdata_s[i] = 32'd0;
    end
    #23;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(req_ready_s[i]), 32'd1);
      chk("rst_valid", 32'(rsp_valid_s[i]), 32'd0);
      chk("rst_rdata", rsp_rdata_s[i], 32'd0);
      chk("rst_err", 32'(rsp_err_s[i]), 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // LATENCY=1: back-to-back accepts keep ready high.
    suite(0);
    @(negedge clk);
    chk("l1_ready_after", 32'(req_ready_s[0]), 32'd1);

    // LATENCY=3 functional suite.
    suite(1);

    // LATENCY=3: ready low for two cycles, response in the third, and a
    // request accepted during RESP.
    ld(1, 2'd2, 1'b0, 32'h10);
    @(negedge clk); chk("l3_ready_c1", 32'(req_ready_s[1]), 32'd0);
    @(negedge clk); chk("l3_ready_c2", 32'(req_ready_s[1]), 32'd0);
    @(negedge clk); chk("l3_valid_c3", 32'(rsp_valid_s[1]), 32'd1);
    issue(1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1);
    ld(1, 2'd1, 1'b0, 32'h22);

    // Reset during WAIT drops the pending response; memory survives.
    w = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && w < 100) begin @(negedge clk); w++; end
    ld(1, 2'd2, 1'b0, 32'h20);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rstw_valid", 32'(rsp_valid_s[1]), 32'd0);
    chk("rstw_ready", 32'(req_ready_s[1]), 32'd1);
    sb1.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstw_ready_after", 32'(req_ready_s[1]), 32'd1);
    chk("rstw_rdata_after", rsp_rdata_s[1], 32'd0);
    ld(1, 2'd2, 1'b0, 32'h10);
    ld(0, 2'd2, 1'b0, 32'h20);

    w = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && w < 100) begin @(negedge clk); w++; end
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised, byte-lane data memory for the RISC-V core's load/store path. It replaces the word-only data memory with a request/response handshake and byte, half and word stores with per-lane write masks. Loads are size-aware and sign- or zero-extended. Responses arrive after a configurable latency, and out-of-range or illegal accesses are flagged. It sits between the execute stage's load/store unit and writeback.

## Interface
Parameters:
- ADDR_W, 32: byte-address width.
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, at least 4.
- LATENCY, 1: cycles from request acceptance to response; must be at least 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for word and for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; valid only with rsp_valid.

## Operation
- Accept: a request is accepted on a rising edge where req_valid and req_ready are both 1.
- Word index: req_addr[$clog2(DEPTH_WORDS)+1:2].
- Range error: any req_addr bit above the word index is nonzero.
- Size error: req_size = 11.
- Erroring requests do not write memory, and return rsp_rdata = 0 with rsp_err = 1.
- Lane mask: byte uses 1 << addr[1:0]; half uses 0011 << addr[1:0]; word uses 1111.
- Store data replication: byte replicates wdata[7:0] across all 4 lanes; half replicates wdata[15:0] across both halves.
- Store commit: memory is written on the accept edge, masked lanes only.
- Load sampling: the full word is sampled into a response register on the accept edge. Lane extraction and extension use the captured addr[1:0], size and unsigned flag.
- Read-after-write: a request accepted after a store sees the new data. There is no same-edge hazard, because only one request is accepted per edge.
- FSM, IDLE:
  - req_ready = 1.
  - On accept: go to RESP if LATENCY = 1; otherwise go to WAIT with cnt = LATENCY-2.
- FSM, WAIT:
  - req_ready = 0.
  - Decrement cnt; go to RESP when cnt = 0.
- FSM, RESP:
  - rsp_valid = 1 and req_ready = 1.
  - On accept: re-enter per the IDLE rule.
  - Otherwise: go to IDLE.
- There is no response backpressure; the consumer must take rsp_* in the cycle rsp_valid is high.

## Timing
- Reset values: state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cnt = 0. Memory contents are not reset.
- Response timing: rsp_valid rises LATENCY cycles after the accept edge and lasts exactly 1 cycle.
- Throughput: one request per LATENCY cycles. With LATENCY = 1, back-to-back requests are accepted every cycle.
- Output stability: rsp_rdata and rsp_err are registered and change only on the edge that raises rsp_valid. They hold their value until the next response edge.
- Reset mid-operation: any pending response is dropped and rsp_valid drops immediately. A store committed before reset remains in memory.
- Boundaries:
  - Address DEPTH_WORDS*4-1 is the last legal byte.
  - Address DEPTH_WORDS*4 gives a range error.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, responds with rsp_err = 1.
  - No write occurs and rsp_rdata = 0.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Address low bits are forced to alignment: half clears bit 0, word clears bits [1:0].
  - Misalignment never raises rsp_err; range and size errors remain.

## Structure
- Package dmem_pkg holds:
  - size_t enum: SZ_B, SZ_H, SZ_W, SZ_ILL.
  - state_t enum: IDLE, WAIT, RESP.
  - Functions lane_mask(size, off) and load_extend(word, size, off, unsigned).
- Sub-module dmem_byte_ram (parameter DEPTH_WORDS) is the storage array: four 8-bit lanes, a 4-bit write mask, synchronous write, and a registered read.
- The FSM, error decode and extension live in the top module.

## Test plan
- Store word 0xDEADBEEF at address 0x10, then load word from 0x10 → rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid pulse LATENCY cycles after each accept.
- Store byte 0x80 at 0x13 over that word, then LB at 0x13 → 0xFFFFFF80; LBU at 0x13 → 0x00000080; LW at 0x10 → 0x80ADBEEF.
- Store half 0x1234 at 0x22, then LH at 0x22 → 0x00001234; LW at 0x20 → 0x1234xxxx with the lower half unchanged.
- Store at address DEPTH_WORDS*4, and separately any request with req_size = 11 → rsp_err = 1, rsp_rdata = 0, memory unchanged on readback.
- Word store at 0x31:
  - With DMEM_MISALIGN_TRAP_EN: rsp_err = 1, no write.
  - Without it: data is written at 0x30 and rsp_err = 0.
- With LATENCY = 3:
  - req_ready = 0 for 2 cycles after accept; rsp_valid in cycle 3.
  - A request accepted in RESP yields the next rsp_valid 3 cycles later.
  - Asserting rstn = 0 in WAIT gives rsp_valid = 0, req_ready = 1 after release, and no stray response.
